// File: rtl/risc_v_multicycle_controller.sv
// Multi-cycle RV32I-subset control FSM; outputs decode the state register (FETCH/BRANCH write enables also see memReady/zero/neg).
// 3-5 cycles per instruction with zero-wait memory; memReq is held, and the state waits, until memReady.
module risc_v_multicycle_controller (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       neg,
    input  logic       memReady,
    output logic       memReq,
    output logic       memWrite,
    output logic       adrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       regWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic [1:0] resultSrc,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_READ, MEM_WB,
        MEM_WRITE, BRANCH, JAL, JALR_ADR, JALR_JMP, LUI, ERROR
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
                           ALU_XOR = 3'b100, ALU_SLT = 3'b101, ALU_SLTU = 3'b110;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011,
                           IMM_U = 3'b100;

    state_t     state;
    logic       r_ok, i_ok, br_ok, taken;
    logic [2:0] r_ctl, i_ctl;

    // Function-field decode; only meaningful once the IR holds the instruction.
    always_comb begin
        r_ok  = 1'b1;
        r_ctl = ALU_ADD;
        case (func3)
            3'b000: begin
                if (func7 == 7'b0100000)      r_ctl = ALU_SUB;
                else if (func7 != 7'b0000000) r_ok  = 1'b0;
            end
            3'b111:  r_ctl = ALU_AND;
            3'b110:  r_ctl = ALU_OR;
            3'b100:  r_ctl = ALU_XOR;
            3'b010:  r_ctl = ALU_SLT;
            3'b011:  r_ctl = ALU_SLTU;
            default: r_ok  = 1'b0;
        endcase
        i_ok  = 1'b1;
        i_ctl = ALU_ADD;
        case (func3)
            3'b000:  i_ctl = ALU_ADD;
            3'b100:  i_ctl = ALU_XOR;
            3'b110:  i_ctl = ALU_OR;
            3'b111:  i_ctl = ALU_AND;
            3'b010:  i_ctl = ALU_SLT;
            3'b011:  i_ctl = ALU_SLTU;
            default: i_ok  = 1'b0;
        endcase
        br_ok = 1'b1;
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = neg;
            3'b101:  taken = !neg;
            default: br_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:     if (memReady) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_R:    state <= EXEC_R;
                        OP_I:    state <= EXEC_I;
                        OP_LD,
                        OP_ST:   state <= MEM_ADR;
                        OP_BR:   state <= BRANCH;
                        OP_JAL:  state <= JAL;
                        OP_JALR: state <= JALR_ADR;
                        OP_LUI:  state <= LUI;
                        default: state <= ERROR;
                    endcase
                end
                EXEC_R:    state <= r_ok ? ALU_WB : ERROR;
                EXEC_I:    state <= i_ok ? ALU_WB : ERROR;
                ALU_WB:    state <= FETCH;
                MEM_ADR:   state <= (op == OP_ST) ? MEM_WRITE : MEM_READ;
                MEM_READ:  if (memReady) state <= MEM_WB;
                MEM_WB:    state <= FETCH;
                MEM_WRITE: if (memReady) state <= FETCH;
                BRANCH:    state <= br_ok ? FETCH : ERROR;
                JAL:       state <= ALU_WB;
                JALR_ADR:  state <= JALR_JMP;
                JALR_JMP:  state <= ALU_WB;
                LUI:       state <= FETCH;
                default:   state <= ERROR;
            endcase
        end
    end

    always_comb begin
        memReq     = 1'b0;
        memWrite   = 1'b0;
        adrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        regWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        immSrc     = IMM_I;
        resultSrc  = 2'b00;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                memReq    = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 2'b10;
                IRWrite   = memReady;
                PCWrite   = memReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
            end
            EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = r_ctl;
            end
            EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = i_ctl;
            end
            ALU_WB:   regWrite = 1'b1;
            MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immSrc  = (op == OP_ST) ? IMM_S : IMM_I;
            end
            MEM_READ: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
            end
            MEM_WB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            MEM_WRITE: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = br_ok & taken;
            end
            // PC takes the target formed in DECODE while the ALU builds the link value.
            JAL, JALR_JMP: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            JALR_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            LUI: begin
                immSrc    = IMM_U;
                resultSrc = 2'b11;
                regWrite  = 1'b1;
            end
            ERROR:    illegal = 1'b1;
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_risc_v_multicycle_controller.sv
// Randomized bench for the multi-cycle controller: each instruction is summarised by a
// per-instruction model (cycle count, write counts, operand selects) and compared with the DUT.
module tb_risc_v_multicycle_controller;
    logic       clk, rstn, zero, neg, memReady;
    logic [6:0] op, func7;
    logic [2:0] func3;
    logic       memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, resultSrc;
    logic [2:0] ALUControl, immSrc;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    risc_v_multicycle_controller dut (
        .clk(clk), .rstn(rstn), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
        .memReady(memReady), .memReq(memReq), .memWrite(memWrite), .adrSrc(adrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .immSrc(immSrc), .resultSrc(resultSrc),
        .illegal(illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-instruction expectations: cycle totals, how often each enable fires, which ALU
    // operation is applied to the register operand, and which result is written back.
    function automatic void model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic z, input logic n, input int fw, input int dw,
                                  output int cyc, output bit ill, output int rw, output int pcw,
                                  output int mw, output int req, output int adr, output bit has_aop,
                                  output logic [2:0] aop, output logic [2:0] opimm,
                                  output logic [1:0] rsrc);
        bit taken, mem;
        taken = 0; ill = 0; has_aop = 1; rw = 0; cyc = 0;
        aop = 3'b000; opimm = 3'b000; rsrc = 2'b00;
        mem = (o == OP_LD) || (o == OP_ST);
        case (o)
            OP_R: begin
                cyc = 4; rw = 1;
                case (f3)
                    3'b000: if (f7 == 7'h00) aop = 3'd0; else if (f7 == 7'h20) aop = 3'd1; else ill = 1;
                    3'b111: aop = 3'd2;
                    3'b110: aop = 3'd3;
                    3'b100: aop = 3'd4;
                    3'b010: aop = 3'd5;
                    3'b011: aop = 3'd6;
                    default: ill = 1;
                endcase
            end
            OP_I: begin
                cyc = 4; rw = 1;
                case (f3)
                    3'b000: aop = 3'd0;
                    3'b100: aop = 3'd4;
                    3'b110: aop = 3'd3;
                    3'b111: aop = 3'd2;
                    3'b010: aop = 3'd5;
                    3'b011: aop = 3'd6;
                    default: ill = 1;
                endcase
            end
            OP_LD:   begin cyc = 5 + dw; rw = 1; rsrc = 2'b01; end
            OP_ST:   begin cyc = 4 + dw; opimm = 3'b001; end
            OP_BR: begin
                cyc = 3; aop = 3'd1;
                case (f3)
                    3'b000: taken = z;
                    3'b001: taken = !z;
                    3'b100: taken = n;
                    3'b101: taken = !n;
                    default: ill = 1;
                endcase
            end
            OP_JAL:  begin cyc = 4; rw = 1; taken = 1; has_aop = 0; end
            OP_JALR: begin cyc = 5; rw = 1; taken = 1; end
            OP_LUI:  begin cyc = 3; rw = 1; rsrc = 2'b11; has_aop = 0; end
            default: ill = 1;
        endcase
        if (ill) begin
            cyc = fw + ((o == OP_R || o == OP_I || o == OP_BR) ? 3 : 2);
            rw = 0; pcw = 1; mw = 0; req = fw + 1; adr = 0; has_aop = 0;
        end else begin
            cyc = cyc + fw;
            pcw = 1 + int'(taken);
            mw  = (o == OP_ST) ? 1 : 0;
            req = fw + 1 + (mem ? dw + 1 : 0);
            adr = mem ? dw + 1 : 0;
        end
    endfunction

    // Starts and ends just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic n,
                             input int fw, input int dw, input int err_hold);
        int cyc, rw, pcw, mw, req, adr, waits;
        bit ill, has_aop;
        logic [2:0] aop, opimm;
        logic [1:0] rsrc;
        int o_rw = 0, o_pcw = 0, o_irw = 0, o_mw = 0, o_req = 0, o_adr = 0, o_aopn = 0;
        logic [2:0] o_aop = 3'b111, o_opimm = 3'b111, o_dimm = 3'b111, o_wimm = 3'b111;
        logic [1:0] o_rsrc = 2'b10;
        logic [2:0] dimm;
        model(o, f3, f7, z, n, fw, dw, cyc, ill, rw, pcw, mw, req, adr, has_aop, aop, opimm, rsrc);
        dimm = (o == OP_JAL) ? 3'b011 : 3'b010;
        op = o; func3 = f3; func7 = f7; zero = z; neg = n; waits = fw;
        for (int c = 0; c < cyc; c++) begin
            #1;
            if (memReq) begin
                if (waits > 0) begin memReady = 1'b0; waits--; end
                else begin memReady = 1'b1; waits = dw; end
            end else begin
                memReady = ($urandom_range(0, 1) == 1);
            end
            #1;
            if (regWrite) begin o_rw++; o_rsrc = resultSrc; o_wimm = immSrc; end
            if (PCWrite) o_pcw++;
            if (IRWrite) o_irw++;
            if (memWrite && memReady) o_mw++;
            if (memReq) o_req++;
            if (memReq && adrSrc) o_adr++;
            if (ALUSrcA == 2'b10) begin
                o_aopn++; o_aop = ALUControl;
                if (ALUSrcB == 2'b01) o_opimm = immSrc;
            end
            if (ALUSrcA == 2'b01 && ALUSrcB == 2'b01) o_dimm = immSrc;
            @(posedge clk);
        end
        n_checks++; if (o_rw !== rw) $display("FAIL %s regwrite_count got %0d want %0d", tag, o_rw, rw); else n_pass++;
        n_checks++; if (o_pcw !== pcw) $display("FAIL %s pcwrite_count got %0d want %0d", tag, o_pcw, pcw); else n_pass++;
        n_checks++; if (o_irw !== 1) $display("FAIL %s irwrite_count got %0d want 1", tag, o_irw); else n_pass++;
        n_checks++; if (o_mw !== mw) $display("FAIL %s memwrite_count got %0d want %0d", tag, o_mw, mw); else n_pass++;
        n_checks++; if (o_req !== req) $display("FAIL %s memreq_cycles got %0d want %0d", tag, o_req, req); else n_pass++;
        n_checks++; if (o_adr !== adr) $display("FAIL %s aluout_addr_cycles got %0d want %0d", tag, o_adr, adr); else n_pass++;
        n_checks++; if (o_dimm !== dimm) $display("FAIL %s decode_imm got %0d want %0d", tag, o_dimm, dimm); else n_pass++;
        if (!ill) begin
            n_checks++;
            if (o_aopn !== (has_aop ? 1 : 0)) $display("FAIL %s reg_operand_cycles got %0d want %0d", tag, o_aopn, has_aop ? 1 : 0);
            else n_pass++;
            if (has_aop) begin
                n_checks++; if (o_aop !== aop) $display("FAIL %s alu_op got %0d want %0d", tag, o_aop, aop); else n_pass++;
            end
            if (o == OP_I || o == OP_LD || o == OP_ST || o == OP_JALR) begin
                n_checks++; if (o_opimm !== opimm) $display("FAIL %s operand_imm got %0d want %0d", tag, o_opimm, opimm); else n_pass++;
            end
            if (rw > 0) begin
                n_checks++; if (o_rsrc !== rsrc) $display("FAIL %s wb_result_src got %0d want %0d", tag, o_rsrc, rsrc); else n_pass++;
            end
            if (o == OP_LUI) begin
                n_checks++; if (o_wimm !== 3'b100) $display("FAIL %s lui_imm got %0d want 4", tag, o_wimm); else n_pass++;
            end
            #1 memReady = 1'b0;
            #1;
            n_checks++;
            if ({memReq, memWrite, adrSrc, ALUSrcB, illegal, IRWrite} !== 7'b1001000)
                $display("FAIL %s back_in_fetch got %b want 1001000", tag,
                         {memReq, memWrite, adrSrc, ALUSrcB, illegal, IRWrite});
            else n_pass++;
            @(posedge clk);
        end else begin
            for (int k = 0; k < err_hold; k++) begin
                #1 memReady = ($urandom_range(0, 1) == 1);
                #1;
                n_checks++;
                if ({illegal, memReq, memWrite, regWrite, PCWrite, IRWrite} !== 6'b100000)
                    $display("FAIL %s error_hold[%0d] got %b want 100000", tag, k,
                             {illegal, memReq, memWrite, regWrite, PCWrite, IRWrite});
                else n_pass++;
                @(posedge clk);
            end
            #1 memReady = 1'b0; rstn = 1'b0;
            #1;
            n_checks++;
            if ({illegal, memReq} !== 2'b01) $display("FAIL %s error_cleared got %b want 01", tag, {illegal, memReq});
            else n_pass++;
            #1 rstn = 1'b1;
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, illegal} !== 7'b1000000)
            $display("FAIL reset_enables got %b want 1000000", {memReq, memWrite, adrSrc, IRWrite, PCWrite, regWrite, illegal});
        else n_pass++;
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl, resultSrc} !== 9'b00_10_000_10)
            $display("FAIL reset_fetch_selects got %b want 001000010", {ALUSrcA, ALUSrcB, ALUControl, resultSrc});
        else n_pass++;
        memReady = 1'b1;
        #1;
        n_checks++;
        if ({IRWrite, PCWrite} !== 2'b11) $display("FAIL reset_fetch_ready got %b want 11", {IRWrite, PCWrite});
        else n_pass++;
        memReady = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_add();
        run_instr("add", OP_R, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 0);
        run_instr("sub", OP_R, 3'b000, 7'h20, 1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait2", OP_LD, 3'b010, 7'h00, 1'b0, 1'b0, 0, 2, 0);
        run_instr("sw_wait1", OP_ST, 3'b010, 7'h00, 1'b0, 1'b0, 1, 1, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", OP_BR, 3'b000, 7'h00, 1'b1, 1'b0, 0, 0, 0);
        run_instr("beq_not", OP_BR, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 0);
        run_instr("blt_taken", OP_BR, 3'b100, 7'h00, 1'b0, 1'b1, 0, 0, 0);
    endtask

    task automatic test_jal_jalr();
        run_instr("jal", OP_JAL, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 0);
        run_instr("jalr", OP_JALR, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 0);
        run_instr("lui", OP_LUI, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 7'b1111111, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0, 20);
    endtask

    task automatic test_reset_mid_write();
        op = OP_ST; func3 = 3'b010; func7 = 7'h00;
        #1 memReady = 1'b1;
        @(posedge clk);
        #1 memReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({memReq, memWrite, adrSrc} !== 3'b111) $display("FAIL mw_pending got %b want 111", {memReq, memWrite, adrSrc});
        else n_pass++;
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if ({memReq, memWrite, adrSrc, regWrite} !== 4'b1000)
            $display("FAIL mw_abort got %b want 1000", {memReq, memWrite, adrSrc, regWrite});
        else n_pass++;
        memReady = 1'b1;
        #1;
        n_checks++;
        if (memWrite !== 1'b0) $display("FAIL mw_no_write got %b want 0", memWrite);
        else n_pass++;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({memReq, ALUSrcA, ALUSrcB} !== 5'b0_01_01)
            $display("FAIL release_with_ready got %b want 00101", {memReq, ALUSrcA, ALUSrcB});
        else n_pass++;
        memReady = 1'b0; rstn = 1'b0;
        #1 rstn = 1'b1;
        @(posedge clk);
        run_instr("after_abort", OP_I, 3'b111, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            logic [6:0] o, f7;
            logic [2:0] f3;
            int sel;
            sel = $urandom_range(0, 8);
            case (sel)
                0: o = OP_R;  1: o = OP_I;  2: o = OP_LD;  3: o = OP_ST;  4: o = OP_BR;
                5: o = OP_JAL; 6: o = OP_JALR; 7: o = OP_LUI;
                default: begin
                    o = 7'($urandom);
                    if (o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI}) o = 7'h7f;
                end
            endcase
            f3 = 3'($urandom);
            f7 = 7'h00;
            if (o == OP_R && f3 == 3'b000) begin
                sel = $urandom_range(0, 2);
                f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
            end
            run_instr($sformatf("rand%0d", k), o, f3, f7, ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 3), 3);
        end
    endtask

    initial begin
        rstn = 1'b0; memReady = 1'b0; zero = 1'b0; neg = 1'b0;
        op = 7'h00; func3 = 3'b000; func7 = 7'h00;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal_jalr();
        test_illegal();
        test_reset_mid_write();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/risc_v_multicycle_controller.md
# risc_v_multicycle_controller

Multi-cycle control unit for the RISC-V RV32I-subset datapath. It decodes `op`/`func3`/`func7` held in the datapath's instruction register. Each instruction is sequenced through a Moore state machine that drives every datapath select and write-enable. It stalls on a single shared instruction/data memory through a request/ready handshake and traps illegal opcodes into a sticky error state.

## Interface
Parameters:
- none. All encodings are fixed below.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rstn` in 1: asynchronous, active-low reset.
- `op` in 7: instruction opcode from the instruction register.
- `func3` in 3: instruction bits [14:12].
- `func7` in 7: instruction bits [31:25].
- `zero` in 1: ALU result is zero.
- `neg` in 1: ALU result is negative.
- `memReady` in 1: memory has completed the current access this cycle.
- `memReq` out 1: memory access requested.
- `memWrite` out 1: the request is a write.
- `adrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load the instruction register and the oldPC register.
- `PCWrite` out 1: load the PC from the result bus.
- `regWrite` out 1: register file write.
- `ALUSrcA` out 2: 00 = PC, 01 = oldPC, 10 = A register.
- `ALUSrcB` out 2: 00 = B register, 01 = immExt, 10 = constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.
- `immSrc` out 3: 000 I, 001 S, 010 B, 011 J, 100 U.
- `resultSrc` out 2: 00 ALUOut, 01 data register, 10 ALUResult, 11 immExt.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
Outputs are a pure function of the state register. Every signal not listed for a state is 0.

States:
- FETCH
  - Outputs: memReq, adrSrc=0, ALUSrcA=00, ALUSrcB=10, add, resultSrc=10.
  - IRWrite and PCWrite are asserted only while memReady=1.
  - Stays in FETCH until memReady=1, then goes to DECODE.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, add, so ALUOut = branch or jump target.
  - immSrc = J if op is 1101111, else B.
  - Next state by opcode:
    - R (0110011) → EXEC_R
    - I-ALU (0010011) → EXEC_I
    - load (0000011) / store (0100011) → MEM_ADR
    - branch (1100011) → BRANCH
    - jal (1101111) → JAL
    - jalr (1100111) → JALR_ADR
    - lui (0110111) → LUI
    - any other → ERROR
- EXEC_R
  - Outputs: ALUSrcA=10, ALUSrcB=00.
  - ALU op by func3/func7: 000/0000000 add, 000/0100000 sub, 111 and, 110 or, 100 xor, 010 slt, 011 sltu.
  - Any other combination → ERROR; otherwise → ALU_WB.
- EXEC_I
  - Outputs: ALUSrcA=10, ALUSrcB=01, immSrc=I.
  - ALU op by func3: 000 add, 100 xor, 110 or, 111 and, 010 slt, 011 sltu.
  - Any other func3 → ERROR; otherwise → ALU_WB.
- ALU_WB: resultSrc=00, regWrite. Next state FETCH.
- MEM_ADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, add. immSrc = S for store, I for load.
  - Next: MEM_WRITE for store, MEM_READ for load.
- MEM_READ: memReq, adrSrc=1. Stays until memReady=1, then → MEM_WB.
- MEM_WB: resultSrc=01, regWrite. Next state FETCH.
- MEM_WRITE: memReq, memWrite, adrSrc=1. Stays until memReady=1, then → FETCH.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, resultSrc=00.
  - PCWrite equals `taken`, where taken is:
    - beq(000): zero
    - bne(001): !zero
    - blt(100): neg
    - bge(101): !neg
  - Other func3 → ERROR with PCWrite=0; otherwise → FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, add, resultSrc=00, PCWrite.
  - The PC receives the target while the ALU forms oldPC+4. Next state ALU_WB.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, immSrc=I, add. Next state JALR_JMP.
- JALR_JMP: same outputs as JAL. Next state ALU_WB.
- LUI: immSrc=U, resultSrc=11, regWrite. Next state FETCH.
- ERROR
  - Output: illegal=1. All write enables and memReq are 0.
  - Stays in ERROR until rstn is asserted.

## Timing
- Reset: rstn=0 forces state to FETCH immediately, asynchronously. Outputs then show FETCH values: memReq=1, and all enables 0 while memReady=0. illegal=0.
- Cycle counts with zero-wait memory (memReady=1 every cycle):
  - R, I, branch, lui, sw: 3–4 cycles.
  - jal: 4 cycles.
  - lw, jalr: 5 cycles.
- Each memory wait cycle adds exactly one cycle in the waiting state.
- Handshake:
  - memReq stays high and the address and memWrite stay stable until the cycle memReady=1.
  - The access completes on that cycle's rising edge.
  - memReady is ignored in states that do not assert memReq.
- IRWrite and PCWrite in FETCH are combinational with memReady; both are high for exactly one cycle per fetch.
- Reset mid-instruction aborts the instruction. No regWrite or memWrite is issued after rstn falls.
- If rstn is released at the same time as memReady=1, the fetch proceeds normally on the first edge with rstn=1.

## Test plan
- add x3,x1,x2 (op 0110011, func3 000, func7 0) with memReady=1 → states FETCH, DECODE, EXEC_R, ALU_WB. ALUControl=000 in EXEC_R; regWrite=1 only in ALU_WB; exactly 4 cycles.
- lw with memReady low for 2 cycles in MEM_READ → memReq=1, adrSrc=1 held for 3 cycles. MEM_WB follows with resultSrc=01, regWrite=1; 7 cycles total.
- beq with zero=1, then with zero=0; blt with neg=1 → PCWrite=1, 0, 1 respectively in BRANCH; sub selected; resultSrc=00.
- jal then jalr → PCWrite=1 in JAL / JALR_JMP with resultSrc=00. The next cycle is ALU_WB with regWrite=1. Cycle totals are 4 and 5.
- op=1111111 → DECODE then ERROR. illegal=1 persists for 20 cycles with memReq=0 and all enables 0. rstn pulse returns to FETCH with illegal=0.
- rstn asserted during MEM_WRITE while memReady=0 → immediate FETCH. memWrite drops in the same cycle; no write occurs.
